// File: rtl/axa_pkg.sv
// Shared AXA3 approximate-cell and exact full-adder primitives for the approximate adder and
// subtractor chains.
package axa_pkg;

    localparam int unsigned AXA_MAX_W = 32;

    // b is the already-conditioned operand bit (~b for subtraction); returns {cout, sum}.
    function automatic logic [1:0] axa3_cell(input logic a, input logic b, input logic cin);
        logic x;
        x = ~(a ^ b);
        return {(x ? a : cin), (x & cin)};
    endfunction

    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        return {((a & b) | (a & cin) | (b & cin)), (a ^ b ^ cin)};
    endfunction

endpackage

// File: rtl/axa_sub_chain.sv
// Combinational ripple segment covering absolute bit positions [HI:LO]; positions below
// APPROX_LSBS use the AXA3 cell, the rest exact full adders.
module axa_sub_chain
    import axa_pkg::*;
#(
    parameter int unsigned LO          = 0,
    parameter int unsigned HI          = 7,
    parameter int unsigned APPROX_LSBS = 4
) (
    input  logic [HI-LO:0] i_a,
    input  logic [HI-LO:0] i_bn,
    input  logic           i_cin,
    output logic [HI-LO:0] o_sum,
    output logic           o_cout
);

    logic [1:0] w_cell;
    logic       w_carry;

    always_comb begin
        o_sum   = '0;
        w_cell  = '0;
        w_carry = i_cin;
        for (int unsigned i = 0; i <= HI - LO; i++) begin
            if ((LO + i) < APPROX_LSBS) begin
                w_cell = axa3_cell(i_a[i], i_bn[i], w_carry);
            end else begin
                w_cell = fa_cell(i_a[i], i_bn[i], w_carry);
            end
            o_sum[i] = w_cell[0];
            w_carry  = w_cell[1];
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/axa3_sub16_pipe.sv
// Two-stage pipelined approximate subtractor A - B = A + ~B + 1, chain split at bit W/2,
// with valid/ready handshakes on both sides.
module axa3_sub16_pipe
    import axa_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned APPROX_LSBS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_diff,
    output logic         out_borrow
);

    localparam int unsigned H = W / 2;

    logic [H-1:0] w_bn_lo;
    logic [H-1:0] w_lo_sum;
    logic         w_lo_cout;
    logic [H-1:0] w_hi_sum;
    logic         w_hi_cout;
    logic         w_s2_ready;

    logic         r_s1_valid;
    logic [H-1:0] r_s1_lo_sum;
    logic         r_s1_carry;
    logic [H-1:0] r_s1_a_hi;
    logic [H-1:0] r_s1_bn_hi;
    logic         r_s2_valid;
    logic [W-1:0] r_diff;
    logic         r_borrow;

    assign w_bn_lo = ~in_b[H-1:0];

    axa_sub_chain #(
        .LO          (0),
        .HI          (H - 1),
        .APPROX_LSBS (APPROX_LSBS)
    ) u_chain_lo (
        .i_a    (in_a[H-1:0]),
        .i_bn   (w_bn_lo),
        .i_cin  (1'b1),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    axa_sub_chain #(
        .LO          (H),
        .HI          (W - 1),
        .APPROX_LSBS (APPROX_LSBS)
    ) u_chain_hi (
        .i_a    (r_s1_a_hi),
        .i_bn   (r_s1_bn_hi),
        .i_cin  (r_s1_carry),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    // A stage may refill in the same cycle its contents move downstream.
    assign w_s2_ready = ~r_s2_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_lo_sum <= '0;
            r_s1_carry  <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_bn_hi  <= '0;
            r_s2_valid  <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_diff   <= {w_hi_sum, r_s1_lo_sum};
                    r_borrow <= ~w_hi_cout;
                end
            end
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_lo_sum <= w_lo_sum;
                    r_s1_carry  <= w_lo_cout;
                    r_s1_a_hi   <= in_a[W-1:H];
                    r_s1_bn_hi  <= ~in_b[W-1:H];
                end
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_diff   = r_diff;
    assign out_borrow = r_borrow;

endmodule

// File: tb/tb_axa3_sub16_pipe.sv
// Bench for axa3_sub16_pipe: directed vector table on approximate and exact builds, stall and
// reset sequences, then a randomized handshake scoreboard.
module tb_axa3_sub16_pipe;
    import axa_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_borrow;
    logic [15:0] out_diff;
    logic        in_ready_x, out_valid_x, out_borrow_x;
    logic [15:0] out_diff_x;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axa3_sub16_pipe #(.W(16), .APPROX_LSBS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
        .out_borrow(out_borrow)
    );

    axa3_sub16_pipe #(.W(16), .APPROX_LSBS(0)) dut_ex (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x), .in_a(in_a),
        .in_b(in_b), .out_valid(out_valid_x), .out_ready(out_ready), .out_diff(out_diff_x),
        .out_borrow(out_borrow_x)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d4;
        logic        br4;
        logic [15:0] d0;
        logic        br0;
    } vec_t;

    typedef struct {
        logic [16:0] r4;
        logic [16:0] r0;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Returns {borrow, diff} for a full ripple chain with the given approximate LSB count.
    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                            input int approx);
        logic        c;
        logic [1:0]  r;
        logic [15:0] d;
        c = 1'b1;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < approx) r = axa3_cell(a[i], ~b[i], c);
            else            r = fa_cell(a[i], ~b[i], c);
            d[i] = r[0];
            c    = r[1];
        end
        return {~c, d};
    endfunction

    vec_t        vecs[10];
    logic [15:0] sa[8];
    logic [15:0] sb[8];
    exp_t        q[$];
    exp_t        e;

    initial begin
        int          sent, recv, spurious, cyc;
        logic        held, saw_full;
        logic [15:0] held_diff;
        logic [16:0] r;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 16'h0002, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFF1, 1'b1, 16'hFFFF, 1'b1};
        vecs[2] = '{16'd1000, 16'd1,    16'h03E1, 1'b0, 16'd999,  1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
        vecs[6] = '{16'h8000, 16'h0001, 16'h7FF1, 1'b0, 16'h7FFF, 1'b0};
        vecs[7] = '{16'h00F0, 16'h000F, 16'h00E1, 1'b0, 16'h00E1, 1'b0};
        vecs[8] = '{16'h000A, 16'h0006, 16'h0004, 1'b0, 16'h0004, 1'b0};
        vecs[9] = '{16'h0003, 16'h0005, 16'hFFF6, 1'b1, 16'hFFFE, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready_ex", in_ready_x, 1);
        check("rst_out_diff", out_diff, 0);
        check("rst_out_borrow", out_borrow, 0);

        // Directed vectors, one at a time
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF;
            @(negedge clk);
            check("vec_lat1_valid", out_valid, 0);
            @(negedge clk);
            check("vec_valid", out_valid, 1);
            check("vec_valid_ex", out_valid_x, 1);
            check("vec_diff_a4", out_diff, vecs[i].d4);
            check("vec_borrow_a4", out_borrow, vecs[i].br4);
            check("vec_diff_a0", out_diff_x, vecs[i].d0);
            check("vec_borrow_a0", out_borrow_x, vecs[i].br0);
        end
        @(posedge clk); #1;

        // Stream 8 pairs, consumer stalls cycles 3..6
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'h0100 * i[15:0] + 16'h0011;
            sb[i] = 16'h0023 + i[15:0];
        end
        sent = 0; recv = 0; held = 1'b0; saw_full = 1'b0; held_diff = '0;
        for (cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(posedge clk); #1;
            in_valid  = (sent < 8);
            in_a      = (sent < 8) ? sa[sent] : 16'h0;
            in_b      = (sent < 8) ? sb[sent] : 16'h0;
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (out_valid) begin
                if (held) check("stall_stable", out_diff, held_diff);
                if (out_ready) begin
                    r = ref_sub(sa[recv], sb[recv], 4);
                    check("stream_diff", out_diff, r[15:0]);
                    check("stream_borrow", out_borrow, r[16]);
                    recv++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_diff = out_diff;
                end
            end
            if (!in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) sent++;
        end
        check("stream_count", recv, 8);
        check("stream_in_ready_dropped", saw_full, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset with two results in flight
        #1;
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h0101;
        @(posedge clk); #1;
        in_a = 16'h2222; in_b = 16'h0202;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("inflight_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_diff", out_diff, 0);
        check("midrst_in_ready", in_ready, 1);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("midrst_no_ghost", spurious, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_lat1", out_valid, 0);
        @(negedge clk);
        check("postrst_valid", out_valid, 1);
        check("postrst_diff", out_diff, 16'h0002);
        @(posedge clk); #1;

        // Random valid/ready scoreboard against both builds
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rand_a4", {out_borrow, out_diff}, e.r4);
                    check("rand_a0", {out_borrow_x, out_diff_x}, e.r0);
                end
            end
            if (in_valid && in_ready) begin
                e.r4 = ref_sub(in_a, in_b, 4);
                e.r0 = ref_sub(in_a, in_b, 0);
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                check("drain_a4", {out_borrow, out_diff}, e.r4);
                check("drain_a0", {out_borrow_x, out_diff_x}, e.r0);
            end
            @(posedge clk); #1;
        end
        check("rand_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
